// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the EX-stage control-transfer target generator.
//   - mode encodings for the transfer type presented with each request
//   - default widths used as parameter defaults by pc_target_unit
//   - S1 payload record for the default-width configuration
//   - helper that decides whether a transfer redirects the front end
// ---------------------------------------------------------------------------
package pc_pkg;

    localparam int ADDR_W  = 32;
    localparam int IMM_W   = 16;
    localparam int JADDR_W = 26;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        MODE_BR  = 2'b00,
        MODE_J   = 2'b01,
        MODE_JR  = 2'b10,
        MODE_ILL = 2'b11
    } mode_e;

    typedef struct packed {
        logic              valid;
        mode_e             mode;
        logic              cond;
        logic [ADDR_W-1:0] incr_pc;
        logic [ADDR_W-1:0] operand;
    } s1_payload_t;

    // Branches follow their condition, jumps always redirect, and the
    // illegal encoding never redirects.
    function automatic logic isTaken(input mode_e m, input logic c);
        logic taken;
        taken = 1'b0;
        case (m)
            MODE_BR:          taken = c;
            MODE_J, MODE_JR:  taken = 1'b1;
            default:          taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/pc_operand_gen.sv
// ---------------------------------------------------------------------------
// pc_operand_gen
// Purely combinational operand preparation ahead of the S1 register.
// Decodes the transfer mode and produces the value S1 stores:
//   branch        : sign-extended word offset converted to a byte offset
//   jump          : pseudo-direct target built from PC upper bits + jaddr
//   jump-register : register value unchanged
//   illegal       : zero
// Ports:
//   mode_i        transfer mode (pc_pkg::mode_e encoding)
//   incr_pc_hi_i  upper bits of PC+4 that survive a pseudo-direct jump
//   imm_i         signed branch offset in words
//   jaddr_i       J-type word address
//   rs_val_i      register operand for jump-register
//   operand_o     operand captured by S1
// ADDR_W must exceed JADDR_W+2 so that at least one PC bit is kept.
// ---------------------------------------------------------------------------
module pc_operand_gen #(
    parameter int ADDR_W  = 32,
    parameter int IMM_W   = 16,
    parameter int JADDR_W = 26
) (
    input  logic [1:0]                  mode_i,
    input  logic [ADDR_W-JADDR_W-3:0]   incr_pc_hi_i,
    input  logic [IMM_W-1:0]            imm_i,
    input  logic [JADDR_W-1:0]          jaddr_i,
    input  logic [ADDR_W-1:0]           rs_val_i,
    output logic [ADDR_W-1:0]           operand_o
);
    import pc_pkg::*;

    logic [ADDR_W-1:0] immExt;
    logic [ADDR_W-1:0] brOffset;
    logic [ADDR_W-1:0] jumpTarget;

    // Sign-extend first, then shift, so negative offsets keep their sign
    // across the full address width.
    assign immExt     = {{(ADDR_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
    assign brOffset   = {immExt[ADDR_W-3:0], 2'b00};
    assign jumpTarget = {incr_pc_hi_i, jaddr_i, 2'b00};

    always_comb begin
        operand_o = '0;
        case (mode_e'(mode_i))
            MODE_BR:  operand_o = brOffset;
            MODE_J:   operand_o = jumpTarget;
            MODE_JR:  operand_o = rs_val_i;
            default:  operand_o = '0;
        endcase
    end

endmodule

// File: rtl/pc_target_unit.sv
// ---------------------------------------------------------------------------
// pc_target_unit
// Two-stage pipelined control-transfer target generator for the EX stage.
// S1 captures the request and a precomputed operand; S2 holds the final
// target plus redirect / misaligned / illegal flags. A saturating counter
// tracks how many taken transfers have reached S2.
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   in_valid        request present this cycle
//   mode            00 branch, 01 jump, 10 jump-register, 11 illegal
//   cond            branch-taken condition (branch mode only)
//   incr_pc         PC+4 of the transfer instruction
//   imm             signed branch offset in words
//   jaddr           J-type word address
//   rs_val          register value for jump-register
//   stall           hold both stages and the counter
//   flush           kill both stages on the next edge (beats stall)
//   out_valid       S2 holds a valid result
//   target          computed target address
//   redirect        valid and taken
//   misaligned      valid and target[1:0] != 0
//   illegal         valid and mode was 11
//   redirect_count  saturating count of redirects
// ---------------------------------------------------------------------------
module pc_target_unit #(
    parameter int ADDR_W  = pc_pkg::ADDR_W,
    parameter int IMM_W   = pc_pkg::IMM_W,
    parameter int JADDR_W = pc_pkg::JADDR_W,
    parameter int CNT_W   = pc_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [1:0]          mode,
    input  logic                cond,
    input  logic [ADDR_W-1:0]   incr_pc,
    input  logic [IMM_W-1:0]    imm,
    input  logic [JADDR_W-1:0]  jaddr,
    input  logic [ADDR_W-1:0]   rs_val,
    input  logic                stall,
    input  logic                flush,
    output logic                out_valid,
    output logic [ADDR_W-1:0]   target,
    output logic                redirect,
    output logic                misaligned,
    output logic                illegal,
    output logic [CNT_W-1:0]    redirect_count
);
    import pc_pkg::*;

    logic [ADDR_W-1:0] operand;

    logic              s1Valid_q,   s1Valid_d;
    mode_e             s1Mode_q,    s1Mode_d;
    logic              s1Cond_q,    s1Cond_d;
    logic [ADDR_W-1:0] s1IncrPc_q,  s1IncrPc_d;
    logic [ADDR_W-1:0] s1Operand_q, s1Operand_d;

    logic              s2Valid_q,      s2Valid_d;
    logic [ADDR_W-1:0] s2Target_q,     s2Target_d;
    logic              s2Redirect_q,   s2Redirect_d;
    logic              s2Misaligned_q, s2Misaligned_d;
    logic              s2Illegal_q,    s2Illegal_d;

    logic [CNT_W-1:0]  count_q, count_d;

    logic [ADDR_W-1:0] exTarget;
    logic              exTaken;
    logic              s2Load;

    pc_operand_gen #(
        .ADDR_W  (ADDR_W),
        .IMM_W   (IMM_W),
        .JADDR_W (JADDR_W)
    ) uOperandGen (
        .mode_i       (mode),
        .incr_pc_hi_i (incr_pc[ADDR_W-1:JADDR_W+2]),
        .imm_i        (imm),
        .jaddr_i      (jaddr),
        .rs_val_i     (rs_val),
        .operand_o    (operand)
    );

    // S1 next state. Flush clears the valid bit ahead of everything else;
    // a stall freezes the whole stage and ignores in_valid.
    always_comb begin
        s1Valid_d   = s1Valid_q;
        s1Mode_d    = s1Mode_q;
        s1Cond_d    = s1Cond_q;
        s1IncrPc_d  = s1IncrPc_q;
        s1Operand_d = s1Operand_q;
        if (flush) begin
            s1Valid_d = 1'b0;
        end else if (!stall) begin
            s1Valid_d   = in_valid;
            s1Mode_d    = mode_e'(mode);
            s1Cond_d    = cond;
            s1IncrPc_d  = incr_pc;
            s1Operand_d = operand;
        end
    end

    // Final target from the S1 contents. Branch addition wraps modulo
    // 2^ADDR_W; illegal requests resolve to a zero target.
    always_comb begin
        exTarget = '0;
        case (s1Mode_q)
            MODE_BR:          exTarget = s1IncrPc_q + s1Operand_q;
            MODE_J, MODE_JR:  exTarget = s1Operand_q;
            default:          exTarget = '0;
        endcase
        exTaken = isTaken(s1Mode_q, s1Cond_q);
    end

    assign s2Load = !flush && !stall;

    // S2 next state. Flags are stored already qualified by the S1 valid
    // bit so that a bubble never carries a stale flag forward.
    always_comb begin
        s2Valid_d      = s2Valid_q;
        s2Target_d     = s2Target_q;
        s2Redirect_d   = s2Redirect_q;
        s2Misaligned_d = s2Misaligned_q;
        s2Illegal_d    = s2Illegal_q;
        if (flush) begin
            s2Valid_d = 1'b0;
        end else if (!stall) begin
            s2Valid_d      = s1Valid_q;
            s2Target_d     = exTarget;
            s2Redirect_d   = s1Valid_q && exTaken;
            s2Misaligned_d = s1Valid_q && (exTarget[1:0] != 2'b00);
            s2Illegal_d    = s1Valid_q && (s1Mode_q == MODE_ILL);
        end
    end

    // Count only entries that actually land in S2 as valid and taken;
    // the counter sticks at all-ones once it gets there.
    always_comb begin
        count_d = count_q;
        if (s2Load && s1Valid_q && exTaken && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q   <= 1'b0;
            s1Mode_q    <= MODE_BR;
            s1Cond_q    <= 1'b0;
            s1IncrPc_q  <= '0;
            s1Operand_q <= '0;
        end else begin
            s1Valid_q   <= s1Valid_d;
            s1Mode_q    <= s1Mode_d;
            s1Cond_q    <= s1Cond_d;
            s1IncrPc_q  <= s1IncrPc_d;
            s1Operand_q <= s1Operand_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2Valid_q      <= 1'b0;
            s2Target_q     <= '0;
            s2Redirect_q   <= 1'b0;
            s2Misaligned_q <= 1'b0;
            s2Illegal_q    <= 1'b0;
            count_q        <= '0;
        end else begin
            s2Valid_q      <= s2Valid_d;
            s2Target_q     <= s2Target_d;
            s2Redirect_q   <= s2Redirect_d;
            s2Misaligned_q <= s2Misaligned_d;
            s2Illegal_q    <= s2Illegal_d;
            count_q        <= count_d;
        end
    end

    assign out_valid      = s2Valid_q;
    assign target         = s2Target_q;
    assign redirect       = s2Valid_q && s2Redirect_q;
    assign misaligned     = s2Valid_q && s2Misaligned_q;
    assign illegal        = s2Valid_q && s2Illegal_q;
    assign redirect_count = count_q;

endmodule

// File: tb/tb_pc_target_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_target_unit
// Scoreboard bench: each request pushes its hand-computed result into a
// queue; a monitor pops and compares whenever a freshly loaded result is on
// the outputs. Directed checks cover counter, stall, flush and reset.
// The DUT counter is 2 bits wide so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_pc_target_unit;

    typedef struct {
        logic [31:0] target;
        logic        redirect;
        logic        misaligned;
        logic        illegal;
    } expect_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [1:0]  mode;
    logic        cond;
    logic [31:0] incr_pc;
    logic [15:0] imm;
    logic [25:0] jaddr;
    logic [31:0] rs_val;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic [31:0] target;
    logic        redirect;
    logic        misaligned;
    logic        illegal;
    logic [1:0]  redirect_count;

    expect_t expQ[$];
    int      checkCount = 0;
    int      passCount  = 0;
    logic    newOut;

    pc_target_unit #(
        .ADDR_W  (32),
        .IMM_W   (16),
        .JADDR_W (26),
        .CNT_W   (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .mode           (mode),
        .cond           (cond),
        .incr_pc        (incr_pc),
        .imm            (imm),
        .jaddr          (jaddr),
        .rs_val         (rs_val),
        .stall          (stall),
        .flush          (flush),
        .out_valid      (out_valid),
        .target         (target),
        .redirect       (redirect),
        .misaligned     (misaligned),
        .illegal        (illegal),
        .redirect_count (redirect_count)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // A result on the outputs is new only if the previous edge loaded S2.
    always @(posedge clk or posedge rst) begin
        if (rst) newOut <= 1'b0;
        else     newOut <= !stall && !flush;
    end

    // Monitor: compare fresh results against the scoreboard, and make sure
    // the flags stay low whenever nothing valid is presented.
    always @(negedge clk) begin
        expect_t e;
        if (!rst) begin
            if (out_valid && newOut) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_output", 64'(target), 64'hDEAD);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("target", 64'(target), 64'(e.target));
                    checkOutput("flags", 64'({redirect, misaligned, illegal}),
                                64'({e.redirect, e.misaligned, e.illegal}));
                end
            end
            if (!out_valid) begin
                checkOutput("idle_flags", 64'({redirect, misaligned, illegal}), 64'd0);
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] m, input logic c,
                                 input logic [31:0] pc, input logic [15:0] im,
                                 input logic [25:0] ja, input logic [31:0] rs,
                                 input logic [31:0] eT, input logic eR,
                                 input logic eM, input logic eI);
        expect_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        mode     = m;
        cond     = c;
        incr_pc  = pc;
        imm      = im;
        jaddr    = ja;
        rs_val   = rs;
        e.target     = eT;
        e.redirect   = eR;
        e.misaligned = eM;
        e.illegal    = eI;
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            stall    = 1'b0;
            flush    = 1'b0;
        end
    endtask

    task automatic pulseReset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        expQ.delete();
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        mode     = 2'b00;
        cond     = 1'b0;
        incr_pc  = '0;
        imm      = '0;
        jaddr    = '0;
        rs_val   = '0;
        stall    = 1'b0;
        flush    = 1'b0;

        // Reset state
        #3;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_target", 64'(target), 64'd0);
        checkOutput("rst_flags", 64'({redirect, misaligned, illegal}), 64'd0);
        checkOutput("rst_count", 64'(redirect_count), 64'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;

        // Branch forward: 8 + (1<<2) = 12
        applyStimulus(2'b00, 1'b1, 32'h8, 16'h1, '0, '0, 32'hC, 1'b1, 1'b0, 1'b0);
        idle(4);
        @(negedge clk);
        checkOutput("count_after_first_branch", 64'(redirect_count), 64'd1);

        // Branch backward, wrap, and not-taken
        applyStimulus(2'b00, 1'b1, 32'h100, 16'hFFFF, '0, '0, 32'hFC, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b1, 32'hFFFF_FFFC, 16'h2, '0, '0, 32'h4, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 32'h20, 16'h4, '0, '0, 32'h30, 1'b0, 1'b0, 1'b0);
        idle(4);
        @(negedge clk);
        checkOutput("count_after_branches", 64'(redirect_count), 64'd3);

        // Jump, jump-register (misaligned) and illegal, back to back
        pulseReset();
        applyStimulus(2'b01, 1'b0, 32'h4000_0004, '0, 26'h10, '0, 32'h4000_0040, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b10, 1'b0, 32'h0, '0, '0, 32'h1002, 32'h1002, 1'b1, 1'b1, 1'b0);
        applyStimulus(2'b11, 1'b1, 32'h1234, 16'h7, 26'h5, 32'h77, 32'h0, 1'b0, 1'b0, 1'b1);
        idle(4);
        @(negedge clk);
        checkOutput("count_after_jumps", 64'(redirect_count), 64'd2);

        // Stall held for three edges with S1 and S2 both full
        pulseReset();
        applyStimulus(2'b01, 1'b0, 32'h0, '0, 26'h100, '0, 32'h400, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b10, 1'b0, 32'h0, '0, '0, 32'h2000, 32'h2000, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        stall    = 1'b1;
        in_valid = 1'b1;
        mode     = 2'b00;
        cond     = 1'b1;
        incr_pc  = 32'h500;
        imm      = 16'h1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("stall_target", 64'(target), 64'h400);
            checkOutput("stall_count", 64'(redirect_count), 64'd1);
            @(posedge clk);
            #1;
        end
        stall    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("stall_last_target", 64'(target), 64'h400);
        idle(3);
        @(negedge clk);
        checkOutput("count_after_stall", 64'(redirect_count), 64'd2);

        // Flush with both stages full; current redirect still visible
        pulseReset();
        applyStimulus(2'b01, 1'b0, 32'h1000_0000, '0, 26'h3, '0, 32'h1000_000C, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b0, 32'h1000_0000, '0, 26'h4, '0, 32'h1000_0010, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        jaddr    = 26'h9;
        @(negedge clk);
        checkOutput("flush_cycle_redirect", 64'(redirect), 64'd1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_count", 64'(redirect_count), 64'd1);
        idle(3);
        @(negedge clk);
        checkOutput("flush_count_later", 64'(redirect_count), 64'd1);

        // Flush together with stall: flush wins
        pulseReset();
        applyStimulus(2'b01, 1'b0, 32'h0, '0, 26'h5, '0, 32'h14, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        stall    = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        stall = 1'b0;
        flush = 1'b0;
        expQ.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("flush_stall_out_valid", 64'(out_valid), 64'd0);
        end
        checkOutput("flush_stall_count", 64'(redirect_count), 64'd0);

        // Asynchronous reset in the middle of a stream
        applyStimulus(2'b01, 1'b0, 32'h0, '0, 26'h1, '0, 32'h4, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b0, 32'h0, '0, 26'h2, '0, 32'h8, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b0, 32'h0, '0, 26'h3, '0, 32'hC, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b0, 32'h0, '0, 26'h4, '0, 32'h10, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("async_rst_target", 64'(target), 64'd0);
        checkOutput("async_rst_flags", 64'({redirect, misaligned, illegal}), 64'd0);
        checkOutput("async_rst_count", 64'(redirect_count), 64'd0);
        #1;
        rst = 1'b0;
        expQ.delete();
        applyStimulus(2'b10, 1'b0, 32'h0, '0, '0, 32'h80, 32'h80, 1'b1, 1'b0, 1'b0);
        idle(4);
        @(negedge clk);
        checkOutput("count_after_reset", 64'(redirect_count), 64'd1);

        // Saturation: five taken jumps on a 2-bit counter
        pulseReset();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(2'b01, 1'b0, 32'h0, '0, 26'(6 + k), '0, 32'(24 + 4 * k),
                          1'b1, 1'b0, 1'b0);
        end
        idle(4);
        @(negedge clk);
        checkOutput("count_saturated", 64'(redirect_count), 64'd3);

        // Every pushed expectation must have been consumed
        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
